vdiv_seq: RTL and testbench

VDIV_SEQ -- requirements
Module: vdiv_seq

---
 rtl/vdiv_seq.sv | 178 +++++++++++++++++
 tb/tb_vdiv_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdiv_seq.sv
// Sequential e32 vector divide/remainder unit, VLEN 128.
// One element at a time, restoring radix-2, 34 cycles per element.
module vdiv_seq (
  input  logic         clk,
  input  logic         clrn,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         vx,
  input  logic [2:0]   vl,
  input  logic [127:0] va,
  input  logic [127:0] vb,
  input  logic [31:0]  rs,
  input  logic [127:0] vd_old,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [127:0] result
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state, state_n;

  logic [127:0] a_r;
  logic [127:0] b_r;
  logic [1:0]   op_r;
  logic [2:0]   vl_r;
  logic [2:0]   e;
  logic [4:0]   cnt;
  logic [31:0]  rem;
  logic [31:0]  quo;
  logic [31:0]  dvs;
  logic         neg_q;
  logic         neg_r;
  logic         dz;

  logic         accept;
  logic         abort;
  logic [2:0]   vl_c;
  logic [2:0]   e_nx;
  logic [6:0]   base;
  logic [31:0]  ea;
  logic [31:0]  eb;
  logic         sa;
  logic         sb;
  logic [31:0]  mag_a;
  logic [31:0]  mag_b;
  logic [32:0]  tmp;
  logic [32:0]  sub;
  logic         ge;
  logic [31:0]  q_f;
  logic [31:0]  r_f;
  logic [31:0]  wr;

  // op[0] selects signed, op[1] selects remainder
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign accept = (state == IDLE) && start && !cancel;
  assign abort  = (state != IDLE) && cancel;
  assign vl_c   = (vl > 3'd4) ? 3'd4 : vl;
  assign e_nx   = e + 3'd1;
  assign base   = {e[1:0], 5'd0};

  always_comb begin
    ea    = a_r[base +: 32];
    eb    = b_r[base +: 32];
    sa    = op_r[0] & ea[31];
    sb    = op_r[0] & eb[31];
    mag_a = sa ? (32'd0 - ea) : ea;
    mag_b = sb ? (32'd0 - eb) : eb;
  end

  always_comb begin
    tmp = {rem, quo[31]};
    sub = tmp - {1'b0, dvs};
    ge  = ~sub[32];
  end

  // Divide by zero keeps the all-ones quotient regardless of sign
  always_comb begin
    q_f = neg_q ? (32'd0 - quo) : quo;
    r_f = neg_r ? (32'd0 - rem) : rem;
    if (dz) q_f = 32'hFFFF_FFFF;
    wr = op_r[1] ? r_f : q_f;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept)
            state_n = (vl_c == 3'd0) ? DONE : LOAD;
        end
        LOAD: state_n = ITER;
        ITER: begin
          if (cnt == 5'd31) state_n = FIX;
        end
        FIX: begin
          state_n = (e_nx < vl_r) ? LOAD : DONE;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      vl_r   <= '0;
      e      <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      result <= '0;
    end else if (abort) begin
      e   <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_r    <= va;
            b_r    <= vx ? {4{rs}} : vb;
            op_r   <= op;
            vl_r   <= vl_c;
            result <= vd_old;
            e      <= '0;
            cnt    <= '0;
          end
        end
        LOAD: begin
          rem   <= '0;
          quo   <= mag_a;
          dvs   <= mag_b;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          dz    <= (eb == 32'd0);
          cnt   <= '0;
        end
        ITER: begin
          rem <= ge ? sub[31:0] : tmp[31:0];
          quo <= {quo[30:0], ge};
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          result[base +: 32] <= wr;
          e <= e_nx;
        end
        default: begin
          e   <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdiv_seq.sv
// Bench for vdiv_seq: vector table, random model checks,
// and hand sequences for restart, cancel and mid-op reset.
module tb_vdiv_seq;

  logic         clk;
  logic         clrn;
  logic         start;
  logic [1:0]   op;
  logic         vx;
  logic [2:0]   vl;
  logic [127:0] va;
  logic [127:0] vb;
  logic [31:0]  rs;
  logic [127:0] vd_old;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [127:0] result;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0]   op;
    logic         vx;
    logic [2:0]   vl;
    logic [127:0] va;
    logic [127:0] vb;
    logic [31:0]  rs;
    logic [127:0] vdo;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  typedef struct {
    logic [127:0] res;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[8];

  localparam logic [127:0] VA =
    {32'h8000_0000, 32'hFFFF_FFF6, 32'd7, 32'd100};
  localparam logic [127:0] VB =
    {32'hFFFF_FFFF, 32'd3, 32'd0, 32'd7};

  vdiv_seq dut (
    .clk    (clk),
    .clrn   (clrn),
    .start  (start),
    .op     (op),
    .vx     (vx),
    .vl     (vl),
    .va     (va),
    .vb     (vb),
    .rs     (rs),
    .vd_old (vd_old),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] o, input logic x, input logic [2:0] l,
    input logic [127:0] a, input logic [127:0] b,
    input logic [31:0] s, input logic [127:0] d,
    input logic [127:0] ex, input int lt);
    vec_t v;
    v.op = o; v.vx = x; v.vl = l; v.va = a; v.vb = b;
    v.rs = s; v.vdo = d; v.exp = ex; v.lat = lt;
    return v;
  endfunction

  function automatic logic [127:0] model(
    input logic [1:0] o, input logic x, input logic [2:0] l,
    input logic [127:0] a, input logic [127:0] b,
    input logic [31:0] s, input logic [127:0] d);
    logic [127:0] r;
    logic [31:0]  ai, bi, q, rm;
    int n;
    n = (l > 3'd4) ? 4 : int'(l);
    r = d;
    for (int i = 0; i < n; i++) begin
      ai = a[i*32 +: 32];
      bi = x ? s : b[i*32 +: 32];
      if (bi == 32'd0) begin
        q = 32'hFFFF_FFFF; rm = ai;
      end else if (o[0]) begin
        if (ai == 32'h8000_0000 && bi == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000; rm = 32'd0;
        end else begin
          q  = $signed(ai) / $signed(bi);
          rm = $signed(ai) % $signed(bi);
        end
      end else begin
        q = ai / bi; rm = ai % bi;
      end
      r[i*32 +: 32] = o[1] ? rm : q;
    end
    return r;
  endfunction

  // kind: 0 plain, 1 restart pulse at cycle 'at',
  // 2 cancel at cycle 'at', 3 reset at cycle 'at'
  task automatic run_op(input vec_t v, input int kind, input int at);
    exp_t e;
    int   bcnt;
    int   dcnt;
    bit   fin;
    bit   cut;
    @(negedge clk);
    op = v.op; vx = v.vx; vl = v.vl; va = v.va; vb = v.vb;
    rs = v.rs; vd_old = v.vdo; start = 1'b1;
    if (kind < 2) begin
      e.res = v.exp; e.lat = v.lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    va = {$urandom, $urandom, $urandom, $urandom};
    vb = {$urandom, $urandom, $urandom, $urandom};
    rs = $urandom; vd_old = {4{$urandom}}; op = ~v.op;
    bcnt = 0; fin = 0; cut = 0;
    for (int c = 1; c <= 300 && !fin && !cut; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (kind == 1) start = (c == at);
      if (done && kind < 2) begin
        fin = 1;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("latency", 128'(c), 128'(e.lat));
        chk("busy_cycles", 128'(bcnt), 128'(e.lat));
      end
      if (kind == 2 && c == at) begin
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 128'(busy), 128'(0));
        cut = 1;
      end
      if (kind == 3 && c == at) begin
        clrn = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_result", result, 128'(0));
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_no_accept", 128'(busy), 128'(0));
        start = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        cut = 1;
      end
    end
    if (kind < 2 && !fin) begin
      n_chk++; n_fail++;
      void'(sbq.pop_front());
      $display("FAIL timeout: no done within 300 cycles");
    end
    if (kind >= 2) begin
      dcnt = 0;
      repeat (160) begin
        @(negedge clk);
        if (done) dcnt++;
      end
      chk("no_done_after_abort", 128'(dcnt), 128'(0));
    end else begin
      @(negedge clk);
      chk("idle_busy", 128'(busy), 128'(0));
      chk("idle_done", 128'(done), 128'(0));
    end
  endtask

  initial begin
    vec_t v;
    n_chk = 0; n_fail = 0;
    clrn = 1'b0; start = 1'b0; cancel = 1'b0;
    op = '0; vx = 1'b0; vl = '0;
    va = '0; vb = '0; rs = '0; vd_old = '0;

    tbl[0] = mk(2'b00, 1'b0, 3'd4, VA, VB, 32'd0, '0,
      {32'd0, 32'h5555_5552, 32'hFFFF_FFFF, 32'd14}, 137);
    tbl[1] = mk(2'b01, 1'b0, 3'd4, VA, VB, 32'd0, '0,
      {32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14}, 137);
    tbl[2] = mk(2'b11, 1'b0, 3'd4, VA, VB, 32'd0, '0,
      {32'd0, 32'hFFFF_FFFF, 32'd7, 32'd2}, 137);
    tbl[3] = mk(2'b10, 1'b0, 3'd4, VA, VB, 32'd0, '0,
      {32'h8000_0000, 32'd0, 32'd7, 32'd2}, 137);
    tbl[4] = mk(2'b01, 1'b1, 3'd2,
      {32'd0, 32'd0, 32'hFFFF_FFF6, 32'd100}, VB, 32'd4,
      {4{32'hAAAA_AAAA}},
      {32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hFFFF_FFFE, 32'd25}, 69);
    tbl[5] = mk(2'b00, 1'b0, 3'd0, VA, VB, 32'd0,
      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1);
    tbl[6] = mk(2'b00, 1'b0, 3'd7, VA, VB, 32'd0, '0,
      {32'd0, 32'h5555_5552, 32'hFFFF_FFFF, 32'd14}, 137);
    tbl[7] = mk(2'b11, 1'b0, 3'd1, {96'd0, 32'hFFFF_FFFB},
      '0, 32'd0, {4{32'h1111_1111}},
      {{3{32'h1111_1111}}, 32'hFFFF_FFFB}, 35);

    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_result", result, 128'(0));
    clrn = 1'b1;

    for (int i = 0; i < 8; i++) run_op(tbl[i], 0, 0);

    for (int i = 0; i < 6; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.vx = 1'($urandom_range(0, 1));
      v.vl = 3'($urandom_range(1, 4));
      v.va = {$urandom, $urandom, $urandom, $urandom};
      v.vb = '0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) != 0)
          v.vb[k*32 +: 32] = $urandom >> $urandom_range(0, 31);
      if (i == 0) v.va[31:0] = 32'h8000_0000;
      if (i == 0) v.vb[31:0] = 32'hFFFF_FFFF;
      v.rs  = (i == 1) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      v.vdo = {$urandom, $urandom, $urandom, $urandom};
      v.exp = model(v.op, v.vx, v.vl, v.va, v.vb, v.rs, v.vdo);
      v.lat = 34 * int'(v.vl) + 1;
      run_op(v, 0, 0);
    end

    run_op(tbl[0], 1, 10);
    run_op(tbl[1], 2, 40);
    run_op(tbl[2], 3, 50);
    run_op(tbl[3], 0, 0);

    @(negedge clk);
    start = 1'b1; cancel = 1'b1; vl = 3'd4;
    @(posedge clk);
    #1;
    chk("cancel_beats_start", 128'(busy), 128'(0));
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_beats_start_idle", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
